// File: rtl/pin_chain_sequencer.sv
// Pin-chain self-test sequencer: walks zero/one/walking patterns over the chain
// links, waits a settle interval, and accumulates per-link mismatches.

module pin_chain_link (
   input  logic clk,
   input  logic rst,
   input  logic sense,
   input  logic drive,
   output logic mismatch
);
   logic sync1, sync2;

   // sense is asynchronous to clk; two flops before anything looks at it
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= sense;
         sync2 <= sync1;
      end
   end

   assign mismatch = sync2 ^ drive;
endmodule

module pin_chain_sequencer #(
   parameter int N_LINKS       = 17,
   parameter int SETTLE_CYCLES = 16,
   parameter int NSTEP         = 2*N_LINKS+2,
   parameter int STEP_W        = $clog2(2*N_LINKS+2)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic [N_LINKS-1:0] sense_i,
   output logic [N_LINKS-1:0] drive_o,
   output logic               oe_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               pass_o,
   output logic               aborted_o,
   output logic [N_LINKS-1:0] fail_mask_o,
   output logic [STEP_W-1:0]  fail_step_o
);
   typedef enum logic [1:0] {IDLE, LOAD, SETTLE, CHECK} state_t;

   localparam logic [STEP_W-1:0]  STEP_ONES   = STEP_W'(1);
   localparam logic [STEP_W-1:0]  STEP_WALK1  = STEP_W'(2);
   localparam logic [STEP_W-1:0]  STEP_WALK0  = STEP_W'(N_LINKS+2);
   localparam logic [STEP_W-1:0]  STEP_LAST   = STEP_W'(NSTEP-1);
   localparam logic [7:0]         SETTLE_LAST = 8'(SETTLE_CYCLES-1);
   localparam logic [N_LINKS-1:0] ONE_HOT     = N_LINKS'(1);

   state_t              state, state_nxt;
   logic [STEP_W-1:0]   step;
   logic [7:0]          settle_cnt;
   logic [N_LINKS-1:0]  pattern;
   logic [N_LINKS-1:0]  mismatch;
   logic                abort_run;
   logic                last_step;

   genvar k;
   generate
      for (k = 0; k < N_LINKS; k++) begin : g_link
         pin_chain_link u_link (
            .clk      (clk),
            .rst      (rst),
            .sense    (sense_i[k]),
            .drive    (drive_o[k]),
            .mismatch (mismatch[k])
         );
      end
   endgenerate

   // step -> pattern: zeros, ones, walking one, walking zero
   always_comb begin
      pattern = '0;
      if (step == STEP_ONES)
         pattern = '1;
      else if (step >= STEP_WALK1 && step < STEP_WALK0)
         pattern = ONE_HOT << (step - STEP_WALK1);
      else if (step >= STEP_WALK0)
         pattern = ~(ONE_HOT << (step - STEP_WALK0));
   end

   assign abort_run = abort_i && (state != IDLE);
   assign last_step = (step == STEP_LAST);
   assign busy_o    = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (start_i && !abort_i) state_nxt = LOAD;
         LOAD:   state_nxt = abort_i ? IDLE : SETTLE;
         SETTLE: if (abort_i) state_nxt = IDLE;
                 else if (settle_cnt == SETTLE_LAST) state_nxt = CHECK;
         CHECK:  if (abort_i || last_step) state_nxt = IDLE;
                 else state_nxt = LOAD;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         step        <= '0;
         settle_cnt  <= '0;
         drive_o     <= '0;
         oe_o        <= 1'b0;
         done_o      <= 1'b0;
         pass_o      <= 1'b0;
         aborted_o   <= 1'b0;
         fail_mask_o <= '0;
         fail_step_o <= '0;
      end else begin
         done_o <= 1'b0;
         if (abort_run) begin
            // abort wins over any step work this cycle; partial mask is kept
            drive_o   <= '0;
            oe_o      <= 1'b0;
            aborted_o <= 1'b1;
         end else begin
            case (state)
               IDLE: if (start_i && !abort_i) begin
                  step        <= '0;
                  pass_o      <= 1'b0;
                  aborted_o   <= 1'b0;
                  fail_mask_o <= '0;
                  fail_step_o <= '0;
               end
               LOAD: begin
                  drive_o    <= pattern;
                  oe_o       <= 1'b1;
                  settle_cnt <= '0;
               end
               SETTLE: settle_cnt <= settle_cnt + 8'd1;
               CHECK: begin
                  fail_mask_o <= fail_mask_o | mismatch;
                  // an all-clear mask means no earlier step in this run failed
                  if (mismatch != '0 && fail_mask_o == '0)
                     fail_step_o <= step;
                  if (last_step) begin
                     done_o  <= 1'b1;
                     pass_o  <= ((fail_mask_o | mismatch) == '0);
                     drive_o <= '0;
                     oe_o    <= 1'b0;
                  end else begin
                     step <= step + STEP_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: doc/pin_chain_sequencer.md
# pin_chain_sequencer

Self-test sequencer for the test-jig pin chain. Drives a sequence of patterns onto the chain's output pins, waits a settle interval, and compares each link's returned level against what was driven. It accumulates a per-link fail mask and the first failing step, and reports pass/fail to the RP2040. It sits between the SB_IO output bank (`drive_o`/`oe_o`) and the chain input pins (`sense_i`), replacing the static pin-to-pin forwarding when an FPGA-side check is wanted.

## Interface
- `N_LINKS`, 17: number of chain links; link k drives `drive_o[k]` and returns on `sense_i[k]`.
- `SETTLE_CYCLES`, 16: cycles each pattern is held before the check. Legal range 3..255.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start_i` in 1: begin a run when sampled high in IDLE.
- `abort_i` in 1: RP2040 high-z request; aborts the run and tristates all outputs.
- `sense_i` in N_LINKS: asynchronous chain returns; 2-flop synchronized internally.
- `drive_o` out N_LINKS: pattern to SB_IO `D_OUT_0`.
- `oe_o` out 1: SB_IO `OUTPUT_ENABLE`.
- `busy_o` out 1: run in progress.
- `done_o` out 1: one-cycle pulse at normal completion.
- `pass_o` out 1: last completed run had no mismatches.
- `aborted_o` out 1: last run was aborted.
- `fail_mask_o` out N_LINKS: sticky OR of per-link mismatches for the current/last run.
- `fail_step_o` out STEP_W: index of the first failing step. STEP_W = $clog2(2*N_LINKS+2).

## Operation
- Steps, NSTEP = 2*N_LINKS+2:
  - Step 0: all zeros.
  - Step 1: all ones.
  - Steps 2..N_LINKS+1: walking one, with bit (s-2) set.
  - Steps N_LINKS+2..2*N_LINKS+1: walking zero, with bit (s-N_LINKS-2) clear.
- FSM states:
  - IDLE: `start_i`=1 and `abort_i`=0 → LOAD with step=0. At the same time clear `fail_mask_o`, `fail_step_o`, `pass_o`, `aborted_o`.
  - LOAD: register the step pattern into `drive_o`, set `oe_o`=1, clear the settle counter → SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles → CHECK.
  - CHECK: mismatch = sync(`sense_i`) XOR `drive_o`.
    - OR the mismatch into `fail_mask_o`.
    - If mismatch≠0 and no earlier failure in this run, latch step into `fail_step_o`.
    - If step = NSTEP-1 → IDLE, else step+1 → LOAD.
- Completion (leaving the last CHECK):
  - `done_o` pulses 1 cycle.
  - `pass_o` = (final mask == 0).
  - `drive_o` returns to 0 and `oe_o` to 0.
- Abort: `abort_i`=1 in any non-IDLE state → next cycle IDLE.
  - `oe_o`=0, `drive_o`=0, `busy_o`=0, `aborted_o`=1.
  - No `done_o`; `pass_o` stays 0; `fail_mask_o` holds partial results.
- `start_i` is ignored while busy, and ignored in IDLE while `abort_i`=1.
- Results hold until the next accepted start or reset.
- `busy_o` = (state ≠ IDLE).

## Timing
- Reset values (reset mid-run is identical; no pulse is emitted):
  - State IDLE.
  - `drive_o`=0, `oe_o`=0, `busy_o`=0, `done_o`=0, `pass_o`=0, `aborted_o`=0, `fail_mask_o`=0, `fail_step_o`=0.
  - Synchronizer flops cleared.
- Start sampled in cycle t; `busy_o` goes high in t+1 (LOAD).
- Each step is 1 LOAD + SETTLE_CYCLES SETTLE + 1 CHECK = SETTLE_CYCLES+2 cycles.
- The new pattern appears on `drive_o` in the first SETTLE cycle. During LOAD, `drive_o` still shows the previous step's pattern (0 for step 0).
- SETTLE_CYCLES ≥ 3 covers the pin round trip plus the 2-flop synchronizer. The CHECK comparison uses the synchronized sample registered in that cycle.
- `busy_o` stays high for exactly NSTEP*(SETTLE_CYCLES+2) cycles.
- `done_o` and the `pass_o` update occur in the first IDLE cycle after the final CHECK.
- Abort sampled in cycle t → outputs tristated in t+1. `abort_i` takes priority over step advance in the same cycle.

## Test plan
- **Clean loopback** (N_LINKS=4, SETTLE_CYCLES=3, `sense_i`=`drive_o` via pin model with 1-cycle delay), start → `busy_o` high exactly 50 cycles, then:
  - `done_o` 1-cycle pulse.
  - `pass_o`=1, `fail_mask_o`=4'b0000, `aborted_o`=0.
  - `oe_o`=0, `drive_o`=0.
- **Stuck-at-0 on link 2** → `pass_o`=0, `fail_mask_o`=4'b0100, `fail_step_o`=1.
- **Short links 0 and 1 (wired-AND)** → `fail_step_o`=2, `fail_mask_o`=4'b0011, `pass_o`=0.
- **Abort:** `abort_i` asserted in step 5's SETTLE → next cycle `oe_o`=0, `busy_o`=0, `aborted_o`=1, no `done_o`.
  - Start with `abort_i` high is ignored.
  - A later start clears `aborted_o`.
- **Start while busy:** pulse `start_i` at cycle 20 → ignored; run length stays 50 cycles.
- **Reset mid-run:** `rst` at cycle 30 → all outputs at reset values the next cycle; a fresh run then passes.
